// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 microcode sequencer: FSM states, opcode
// encodings, control-pin indices and the microcode word decoder.
package ssd1306_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDelay,
        StSend,
        StWait,
        StStrAccept,
        StStrSend,
        StStrWait
    } state_e;

    typedef enum logic [3:0] {
        OpSend,
        OpGoto,
        OpDelay,
        OpSetPin,
        OpStream,
        OpRet,
        OpStop,
        OpNop,
        OpBad
    } op_e;

    localparam int unsigned InterpBit = 9;
    localparam int unsigned LastBit   = 8;

    localparam logic [7:0] MaskGoto   = 8'h80;
    localparam logic [7:0] MaskDelay  = 8'hC0;
    localparam logic [7:0] CodeDelay  = 8'h40;
    localparam logic [7:0] MaskSetPin = 8'hE0;
    localparam logic [7:0] CodeSetPin = 8'h20;
    localparam logic [7:0] CodeStream = 8'h10;
    localparam logic [7:0] CodeRet    = 8'h03;
    localparam logic [7:0] CodeStop   = 8'h01;
    localparam logic [7:0] CodeNop    = 8'h00;

    localparam int unsigned PinRstn  = 0;
    localparam int unsigned PinVbatn = 1;
    localparam int unsigned PinVcdn  = 2;
    localparam int unsigned PinDc    = 3;

    function automatic op_e decode_op(input logic interp, input logic [7:0] opc);
        op_e res;
        if (!interp)                                res = OpSend;
        else if ((opc & MaskGoto) == MaskGoto)      res = OpGoto;
        else if ((opc & MaskDelay) == CodeDelay)    res = OpDelay;
        else if ((opc & MaskSetPin) == CodeSetPin)  res = OpSetPin;
        else if (opc == CodeStream)                 res = OpStream;
        else if (opc == CodeRet)                    res = OpRet;
        else if (opc == CodeStop)                   res = OpStop;
        else if (opc == CodeNop)                    res = OpNop;
        else                                        res = OpBad;
        return res;
    endfunction

endpackage

// File: rtl/ssd1306_call_stack.sv
// Return-address LIFO for CALL/RET. Push is ignored when full, pop when empty;
// clear has priority over both.
module ssd1306_call_stack #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] top_o
);

    localparam int unsigned SpW = $clog2(Depth + 1);

    logic [SpW-1:0]   sp_q;
    logic [Width-1:0] mem_q [Depth];

    assign full_o  = (sp_q == SpW'(Depth));
    assign empty_o = (sp_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < Depth; i++) begin
                if (sp_q == SpW'(i)) begin
                    mem_q[i] <= data_i;
                end
            end
            sp_q <= sp_q + SpW'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SpW'(1);
        end
    end

    // Top of stack lives one slot below the stack pointer.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (sp_q == SpW'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/ssd1306_sequencer.sv
// Microcode sequencer for the SSD1306 path: fetches words from an external store,
// drives the SPI byte shifter, streams framebuffer bytes and sets OLED control pins.
module ssd1306_sequencer
    import ssd1306_pkg::*;
#(
    parameter int unsigned MICROCODE_SIZE  = 48,
    parameter int unsigned DELAY_SHIFT     = 11,
    parameter int unsigned STACK_DEPTH     = 4,
    parameter int unsigned NUM_PINS        = 4,
    parameter logic [7:0]  PIN_RESET_VALUE = 8'h06,
    localparam int unsigned ADDR_W         = $clog2(MICROCODE_SIZE)
) (
    input  logic                clk_in,
    input  logic                resetn_in,
    input  logic [ADDR_W-1:0]   procedure_offset_in,
    input  logic                procedure_start_in,
    input  logic                abort_in,
    output logic                procedure_done_out,
    output logic                error_out,
    output logic [ADDR_W-1:0]   ucode_addr_out,
    input  logic [9:0]          ucode_data_in,
    output logic                spi_tx_trigger_out,
    output logic [7:0]          spi_data_out,
    output logic                spi_last_byte_out,
    input  logic                spi_ready_in,
    input  logic [7:0]          stream_data_in,
    input  logic                stream_valid_in,
    input  logic                stream_last_in,
    output logic                stream_ready_out,
    output logic [NUM_PINS-1:0] oled_pins_out
);

    localparam int unsigned    CntW    = 6 + DELAY_SHIFT;
    localparam logic [ADDR_W:0] SizeCmp = (ADDR_W + 1)'(MICROCODE_SIZE);

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [CntW-1:0]     delay_cnt_q;
    logic                error_q;
    logic                trigger_q;
    logic [7:0]          data_q;
    logic                last_q;
    logic [NUM_PINS-1:0] pins_q;

    op_e               op;
    logic [7:0]        opc;
    logic              word_last;
    logic [6:0]        target;
    logic [5:0]        dly;
    logic [2:0]        pin_sel;
    logic              pin_val;
    logic [ADDR_W:0]   pc_inc;
    logic              inc_ok;
    logic              target_ok;
    state_e            adv_state;
    logic [CntW-1:0]   dly_load;
    logic              in_fetch;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_clear;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;

    always_comb begin
        opc       = ucode_data_in[7:0];
        word_last = ucode_data_in[LastBit];
        op        = decode_op(ucode_data_in[InterpBit], opc);
        target    = opc[6:0];
        dly       = opc[5:0];
        pin_sel   = opc[3:1];
        pin_val   = opc[0];
        // pc+1 is kept one bit wider so stepping past the last word is caught, not wrapped.
        pc_inc    = {1'b0, pc_q} + (ADDR_W + 1)'(1);
        inc_ok    = (pc_inc != SizeCmp);
        adv_state = inc_ok ? StFetch : StIdle;
        target_ok = ({25'd0, target} < MICROCODE_SIZE);
        dly_load  = (CntW'(dly) << DELAY_SHIFT) - CntW'(1);
    end

    assign in_fetch  = (state_q == StFetch) && !abort_in;
    assign stk_push  = in_fetch && (op == OpGoto) && word_last && target_ok;
    assign stk_pop   = in_fetch && (op == OpRet);
    assign stk_clear = abort_in || ((state_q == StIdle) && procedure_start_in && spi_ready_in);

    ssd1306_call_stack #(
        .Depth (STACK_DEPTH),
        .Width (ADDR_W)
    ) u_call_stack (
        .clk_i   (clk_in),
        .rst_ni  (resetn_in),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .clear_i (stk_clear),
        .data_i  (pc_inc[ADDR_W-1:0]),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .top_o   (stk_top)
    );

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            delay_cnt_q <= '0;
            error_q     <= 1'b0;
            trigger_q   <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            pins_q      <= PIN_RESET_VALUE[NUM_PINS-1:0];
        end else if (abort_in) begin
            // Dropping the trigger is enough; a byte already in the shifter runs to completion.
            state_q   <= StIdle;
            trigger_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (procedure_start_in && spi_ready_in) begin
                        pc_q    <= procedure_offset_in;
                        error_q <= 1'b0;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    unique case (op)
                        OpSend: begin
                            data_q    <= opc;
                            last_q    <= word_last;
                            trigger_q <= 1'b1;
                            state_q   <= StSend;
                        end
                        OpGoto: begin
                            if (!target_ok || (word_last && stk_full)) begin
                                error_q <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                pc_q <= target[ADDR_W-1:0];
                            end
                        end
                        OpDelay: begin
                            if (dly == 6'd0) begin
                                if (inc_ok) pc_q <= pc_inc[ADDR_W-1:0];
                                error_q <= !inc_ok;
                                state_q <= adv_state;
                            end else begin
                                delay_cnt_q <= dly_load;
                                state_q     <= StDelay;
                            end
                        end
                        OpSetPin: begin
                            for (int i = 0; i < NUM_PINS; i++) begin
                                if (pin_sel == 3'(i)) begin
                                    pins_q[i] <= pin_val;
                                end
                            end
                            if (inc_ok) pc_q <= pc_inc[ADDR_W-1:0];
                            error_q <= !inc_ok;
                            state_q <= adv_state;
                        end
                        OpStream: state_q <= StStrAccept;
                        OpRet: begin
                            if (stk_empty) begin
                                error_q <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                pc_q <= stk_top;
                            end
                        end
                        OpStop: state_q <= StIdle;
                        OpNop: begin
                            if (inc_ok) pc_q <= pc_inc[ADDR_W-1:0];
                            error_q <= !inc_ok;
                            state_q <= adv_state;
                        end
                        default: begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end
                    endcase
                end
                StDelay: begin
                    if (delay_cnt_q == '0) begin
                        if (inc_ok) pc_q <= pc_inc[ADDR_W-1:0];
                        error_q <= !inc_ok;
                        state_q <= adv_state;
                    end else begin
                        delay_cnt_q <= delay_cnt_q - CntW'(1);
                    end
                end
                StSend, StStrSend: begin
                    if (!spi_ready_in) begin
                        trigger_q <= 1'b0;
                        state_q   <= (state_q == StSend) ? StWait : StStrWait;
                    end
                end
                StWait: begin
                    if (spi_ready_in) begin
                        if (inc_ok) pc_q <= pc_inc[ADDR_W-1:0];
                        error_q <= !inc_ok;
                        state_q <= adv_state;
                    end
                end
                StStrAccept: begin
                    if (stream_valid_in && spi_ready_in) begin
                        data_q    <= stream_data_in;
                        last_q    <= stream_last_in;
                        trigger_q <= 1'b1;
                        state_q   <= StStrSend;
                    end
                end
                StStrWait: begin
                    if (spi_ready_in) begin
                        if (last_q) begin
                            if (inc_ok) pc_q <= pc_inc[ADDR_W-1:0];
                            error_q <= !inc_ok;
                            state_q <= adv_state;
                        end else begin
                            state_q <= StStrAccept;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign procedure_done_out = (state_q == StIdle);
    assign error_out          = error_q;
    assign ucode_addr_out     = pc_q;
    assign spi_tx_trigger_out = trigger_q;
    assign spi_data_out       = data_q;
    assign spi_last_byte_out  = last_q;
    assign stream_ready_out   = (state_q == StStrAccept) && spi_ready_in;
    assign oled_pins_out      = pins_q;

endmodule

// File: tb/tb_ssd1306_sequencer.sv
// Self-checking bench: behavioural microcode store, SPI shifter model with a byte
// scoreboard, gapped stream source, pc trace and abort/reset scenarios.
module tb_ssd1306_sequencer;

    localparam int unsigned DS = 2;

    logic       clk_in = 1'b0;
    logic       resetn_in;
    logic [5:0] procedure_offset_in;
    logic       procedure_start_in;
    logic       abort_in;
    logic       procedure_done_out;
    logic       error_out;
    logic [5:0] ucode_addr_out;
    logic [9:0] ucode_data_in;
    logic       spi_tx_trigger_out;
    logic [7:0] spi_data_out;
    logic       spi_last_byte_out;
    logic       spi_ready_in;
    logic [7:0] stream_data_in;
    logic       stream_valid_in;
    logic       stream_last_in;
    logic       stream_ready_out;
    logic [3:0] oled_pins_out;

    logic [9:0] rom [64];
    logic [8:0] exp_q [$];
    logic [5:0] pc_log [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_tx = 0;
    int         busy_cnt = 0;
    logic       spi_stall = 1'b0;

    always #5 clk_in = ~clk_in;

    assign ucode_data_in = rom[ucode_addr_out];
    assign spi_ready_in  = (busy_cnt == 0);

    ssd1306_sequencer #(
        .MICROCODE_SIZE  (48),
        .DELAY_SHIFT     (DS),
        .STACK_DEPTH     (4),
        .NUM_PINS        (4),
        .PIN_RESET_VALUE (8'h06)
    ) dut (
        .clk_in              (clk_in),
        .resetn_in           (resetn_in),
        .procedure_offset_in (procedure_offset_in),
        .procedure_start_in  (procedure_start_in),
        .abort_in            (abort_in),
        .procedure_done_out  (procedure_done_out),
        .error_out           (error_out),
        .ucode_addr_out      (ucode_addr_out),
        .ucode_data_in       (ucode_data_in),
        .spi_tx_trigger_out  (spi_tx_trigger_out),
        .spi_data_out        (spi_data_out),
        .spi_last_byte_out   (spi_last_byte_out),
        .spi_ready_in        (spi_ready_in),
        .stream_data_in      (stream_data_in),
        .stream_valid_in     (stream_valid_in),
        .stream_last_in      (stream_last_in),
        .stream_ready_out    (stream_ready_out),
        .oled_pins_out       (oled_pins_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shifter model: takes a byte when triggered while idle, then stays busy 8 cycles.
    always @(negedge clk_in) begin
        if (spi_tx_trigger_out && spi_ready_in && !spi_stall) begin
            check("tx_byte", {23'd0, spi_last_byte_out, spi_data_out},
                  (exp_q.size() > 0) ? {23'd0, exp_q.pop_front()} : 32'hDEAD_BEEF);
            n_tx     <= n_tx + 1;
            busy_cnt <= 8;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(negedge clk_in) begin
        if (!procedure_done_out && (pc_log.size() == 0 || pc_log[$] != ucode_addr_out)) begin
            pc_log.push_back(ucode_addr_out);
        end
    end

    task automatic run_proc(input logic [5:0] off);
        @(negedge clk_in);
        pc_log.delete();
        procedure_offset_in = off;
        procedure_start_in  = 1'b1;
        @(negedge clk_in);
        procedure_start_in  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!procedure_done_out && cycles < budget) begin
            cycles++;
            @(negedge clk_in);
        end
        check(tag, procedure_done_out, 1);
    endtask

    task automatic drive_stream();
        logic [7:0] bytes [3];
        int         t;
        bytes = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            repeat (i + 2) @(negedge clk_in);
            stream_data_in  = bytes[i];
            stream_last_in  = (i == 2);
            stream_valid_in = 1'b1;
            exp_q.push_back({stream_last_in, bytes[i]});
            t = 0;
            #1;
            while (!stream_ready_out && t < 200) begin
                @(negedge clk_in);
                #1;
                t++;
            end
            check("str_accept", stream_ready_out, 1);
            @(negedge clk_in);
            stream_valid_in = 1'b0;
            stream_last_in  = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          tx0;
        logic [3:0]  pins_model;
        logic [9:0]  err_words [6];
        logic        err_exp [6];

        for (int i = 0; i < 64; i++) rom[i] = 10'h201;
        resetn_in           = 1'b0;
        procedure_offset_in = '0;
        procedure_start_in  = 1'b0;
        abort_in            = 1'b0;
        stream_data_in      = '0;
        stream_valid_in     = 1'b0;
        stream_last_in      = 1'b0;
        pins_model          = 4'h6;
        repeat (3) @(negedge clk_in);
        check("rst_done", procedure_done_out, 1);
        check("rst_error", error_out, 0);
        check("rst_pins", oled_pins_out, pins_model);
        check("rst_trigger", spi_tx_trigger_out, 0);
        check("rst_str_ready", stream_ready_out, 0);
        check("rst_addr", ucode_addr_out, 0);
        resetn_in = 1'b1;
        @(negedge clk_in);

        // Set pin, send one byte, stop.
        rom[0] = 10'h221; rom[1] = 10'h0A5; rom[2] = 10'h301;
        exp_q.push_back(9'h0A5);
        pins_model[0] = 1'b1;
        tx0 = n_tx;
        run_proc(6'd0);
        wait_done("t1_done", 200, cyc);
        check("t1_pins", oled_pins_out, pins_model);
        check("t1_ntx", n_tx - tx0, 1);
        check("t1_error", error_out, 0);
        check("t1_sb_empty", exp_q.size(), 0);

        // Delay length: FETCH + d<<DS cycles + STOP fetch; d==0 behaves as NOP.
        rom[3] = 10'h243; rom[4] = 10'h201;
        run_proc(6'd3);
        wait_done("t2_done", 500, cyc);
        check("t2_delay3_cycles", cyc, 2 + (3 << DS));
        rom[5] = 10'h240; rom[6] = 10'h201;
        run_proc(6'd5);
        wait_done("t2b_done", 500, cyc);
        check("t2_delay0_cycles", cyc, 2);

        // CALL/RET trace, then unbounded recursion overflows the stack.
        rom[0] = 10'h385; rom[5] = 10'h203; rom[1] = 10'h201;
        run_proc(6'd0);
        wait_done("t3_done", 200, cyc);
        check("t3_error", error_out, 0);
        check("t3_trace_len", pc_log.size(), 3);
        if (pc_log.size() == 3) begin
            check("t3_pc0", pc_log[0], 0);
            check("t3_pc1", pc_log[1], 5);
            check("t3_pc2", pc_log[2], 1);
        end
        rom[10] = 10'h38A;
        run_proc(6'd10);
        wait_done("t3_nest_done", 200, cyc);
        check("t3_nest_error", error_out, 1);

        // Error cases and the valid GOTO to the last word.
        err_words = '{10'h2B2, 10'h3B0, 10'h203, 10'h202, 10'h211, 10'h2AF};
        err_exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rom[47] = 10'h201;
        for (int i = 0; i < 6; i++) begin
            rom[20] = err_words[i];
            run_proc(6'd20);
            wait_done($sformatf("err_done%0d", i), 200, cyc);
            check($sformatf("err_tbl%0d", i), error_out, err_exp[i]);
        end
        rom[47] = 10'h200;
        run_proc(6'd47);
        wait_done("pc_end_done", 200, cyc);
        check("pc_end_error", error_out, 1);

        // Stream three gapped bytes, then the following send word.
        rom[30] = 10'h210; rom[31] = 10'h1C7; rom[32] = 10'h201;
        tx0 = n_tx;
        fork
            begin
                run_proc(6'd30);
                wait_done("t4_done", 2000, cyc);
            end
            begin
                drive_stream();
                exp_q.push_back(9'h1C7);
            end
        join
        check("t4_error", error_out, 0);
        check("t4_ntx", n_tx - tx0, 4);
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_trace_len", pc_log.size(), 3);
        if (pc_log.size() == 3) begin
            check("t4_pc_last", pc_log[2], 32);
        end

        // Abort during DELAY.
        rom[0] = 10'h27F; rom[1] = 10'h201;
        run_proc(6'd0);
        repeat (10) @(negedge clk_in);
        check("t5_busy", procedure_done_out, 0);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check("t5_dly_done", procedure_done_out, 1);
        check("t5_dly_error", error_out, 0);
        check("t5_dly_pins", oled_pins_out, pins_model);

        // Abort while waiting for a stream byte.
        run_proc(6'd30);
        repeat (3) @(negedge clk_in);
        #1;
        check("t5_str_ready", stream_ready_out, 1);
        @(negedge clk_in);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        check("t5_str_done", procedure_done_out, 1);
        check("t5_str_ready_off", stream_ready_out, 0);
        check("t5_str_error", error_out, 0);
        check("t5_str_pins", oled_pins_out, pins_model);

        // Clean restart after abort.
        rom[40] = 10'h155; rom[41] = 10'h201;
        exp_q.push_back(9'h155);
        tx0 = n_tx;
        run_proc(6'd40);
        wait_done("t5_restart_done", 200, cyc);
        check("t5_restart_error", error_out, 0);
        check("t5_restart_ntx", n_tx - tx0, 1);
        check("t5_restart_sb", exp_q.size(), 0);

        // Asynchronous reset while a byte is being offered.
        spi_stall = 1'b1;
        rom[0] = 10'h0AA; rom[1] = 10'h201;
        run_proc(6'd0);
        repeat (3) @(negedge clk_in);
        check("t6_trigger_high", spi_tx_trigger_out, 1);
        #2;
        resetn_in = 1'b0;
        #1;
        check("t6_rst_trigger", spi_tx_trigger_out, 0);
        check("t6_rst_pins", oled_pins_out, 4'h6);
        @(negedge clk_in);
        resetn_in = 1'b1;
        spi_stall = 1'b0;
        @(negedge clk_in);
        check("t6_done", procedure_done_out, 1);
        check("t6_error", error_out, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
